// File: rtl/residue_tracker.sv
`default_nettype none
// ============================================================================
// Module   : residue_tracker
// Brief    : Bank of per-channel Moore counters that track qualifying serial
//            events modulo MODULUS, with clear, wrap pulse and edge mode.
// Revision : 1.0
// ============================================================================
module residue_tracker #(
  parameter int CHANNELS = 4,
  parameter int MODULUS  = 2,
  parameter int MODE     = 0,
  localparam int CW      = $clog2(MODULUS)
) (
  input  logic                   clock,
  input  logic                   RESET_n,
  input  logic [CHANNELS-1:0]    in_valid,
  input  logic [CHANNELS-1:0]    in_bit,
  input  logic [CHANNELS-1:0]    clear,
  output logic [CHANNELS*CW-1:0] residue,
  output logic [CHANNELS-1:0]    is_zero,
  output logic [CHANNELS-1:0]    wrap
);

  localparam logic [CW-1:0] c_MAX  = CW'(MODULUS - 1);
  localparam logic [CW:0]   c_MOD  = (CW + 1)'(MODULUS);
  localparam logic          c_EDGE = (MODE == 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CW-1:0] r_st;
      logic          r_prev;
      logic          r_wrap;
      logic          w_ev;
      logic          w_bad;

      // In edge mode a 1 only counts when the previous valid sample was 0.
      assign w_ev  = in_valid[gi] & in_bit[gi] & ~(c_EDGE & r_prev);
      assign w_bad = ({1'b0, r_st} >= c_MOD);

      always_ff @(posedge clock) begin
        if (!RESET_n || clear[gi]) begin
          r_st   <= '0;
          r_prev <= 1'b0;
          r_wrap <= 1'b0;
        end else begin
          if (in_valid[gi]) begin
            r_prev <= in_bit[gi];
          end
          if (w_bad) begin
            r_st   <= '0;
            r_wrap <= 1'b0;
          end else if (w_ev) begin
            r_st   <= (r_st == c_MAX) ? '0 : r_st + 1'b1;
            r_wrap <= (r_st == c_MAX);
          end else begin
            r_wrap <= 1'b0;
          end
        end
      end

      assign residue[gi*CW +: CW] = r_st;
      assign is_zero[gi]          = (r_st == '0);
      assign wrap[gi]             = r_wrap;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_residue_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_residue_tracker
// Brief    : Checks three residue_tracker configurations against a modulo
//            counting reference model using directed and random stimulus.
// Revision : 1.0
// ============================================================================
module tb_residue_tracker;

  logic        clock = 1'b0;
  logic        RESET_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_bit = '0;
  logic [3:0]  clear = '0;

  logic [3:0]  res0;
  logic [11:0] res1, res2;
  logic [3:0]  z0, z1, z2, w0, w1, w2;

  int tests = 0;
  int fails = 0;

  int m_cnt [3][4];
  bit m_pv  [3][4];
  bit m_wr  [3][4];

  always #5 clock = ~clock;

  residue_tracker #(.CHANNELS(4), .MODULUS(2), .MODE(0)) dut0 (
    .clock(clock), .RESET_n(RESET_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .residue(res0), .is_zero(z0), .wrap(w0));

  residue_tracker #(.CHANNELS(4), .MODULUS(5), .MODE(0)) dut1 (
    .clock(clock), .RESET_n(RESET_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .residue(res1), .is_zero(z1), .wrap(w1));

  residue_tracker #(.CHANNELS(4), .MODULUS(5), .MODE(1)) dut2 (
    .clock(clock), .RESET_n(RESET_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .residue(res2), .is_zero(z2), .wrap(w2));

  // Reference: count qualifying samples, wrap when the count reaches the modulus.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int m;
      bit edge_mode;
      m = (k == 0) ? 2 : 5;
      edge_mode = (k == 2);
      for (int c = 0; c < 4; c++) begin
        if (!RESET_n || clear[c]) begin
          m_cnt[k][c] = 0;
          m_pv[k][c]  = 0;
          m_wr[k][c]  = 0;
        end else begin
          bit ev;
          ev = in_valid[c] && in_bit[c] && !(edge_mode && m_pv[k][c]);
          if (in_valid[c]) m_pv[k][c] = in_bit[c];
          if (ev) begin
            m_cnt[k][c] = m_cnt[k][c] + 1;
            m_wr[k][c]  = (m_cnt[k][c] == m);
            m_cnt[k][c] = m_cnt[k][c] % m;
          end else begin
            m_wr[k][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        int obs_r;
        bit obs_z, obs_w;
        case (k)
          0: begin obs_r = int'(res0[c]);        obs_z = z0[c]; obs_w = w0[c]; end
          1: begin obs_r = int'(res1[c*3 +: 3]); obs_z = z1[c]; obs_w = w1[c]; end
          default: begin obs_r = int'(res2[c*3 +: 3]); obs_z = z2[c]; obs_w = w2[c]; end
        endcase
        tests++;
        assert (obs_r === m_cnt[k][c]) else begin
          fails++;
          $error("FAIL dut%0d ch%0d residue: observed %0d expected %0d", k, c, obs_r, m_cnt[k][c]);
        end
        tests++;
        assert (obs_z === (m_cnt[k][c] == 0)) else begin
          fails++;
          $error("FAIL dut%0d ch%0d is_zero: observed %0b expected %0b", k, c, obs_z, m_cnt[k][c] == 0);
        end
        tests++;
        assert (obs_w === m_wr[k][c]) else begin
          fails++;
          $error("FAIL dut%0d ch%0d wrap: observed %0b expected %0b", k, c, obs_w, m_wr[k][c]);
        end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic drive(input logic rn, input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] clr);
    RESET_n  = rn;
    in_valid = v;
    in_bit   = b;
    clear    = clr;
    step();
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0; m_pv[k][c] = 0; m_wr[k][c] = 0;
      end

    // Reset held with all inputs active.
    drive(1'b0, 4'hF, 4'hF, 4'h0);
    drive(1'b0, 4'hF, 4'hF, 4'h0);

    // ch0 level counting: bits 1,1,0,1.
    drive(1'b1, 4'b0001, 4'b0001, 4'h0);
    drive(1'b1, 4'b0001, 4'b0001, 4'h0);
    drive(1'b1, 4'b0001, 4'b0000, 4'h0);
    drive(1'b1, 4'b0001, 4'b0001, 4'h0);

    // ch2: six valid 1s.
    drive(1'b1, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b0100, 4'b0100, 4'h0);

    // ch1: bits 1,1, idle gap with bit 0, then 0,1,1.
    drive(1'b1, 4'h0, 4'h0, 4'hF);
    drive(1'b1, 4'b0010, 4'b0010, 4'h0);
    drive(1'b1, 4'b0010, 4'b0010, 4'h0);
    drive(1'b1, 4'b0000, 4'b0000, 4'h0);
    drive(1'b1, 4'b0010, 4'b0000, 4'h0);
    drive(1'b1, 4'b0010, 4'b0010, 4'h0);
    drive(1'b1, 4'b0010, 4'b0010, 4'h0);

    // All channels advance, then ch3 is cleared together with an event.
    drive(1'b1, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hF, (i % 2 == 0) ? 4'hF : 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hF, 4'hF, 4'h0);
    drive(1'b1, 4'hF, 4'hF, 4'b1000);
    drive(1'b1, 4'hF, 4'h0, 4'h0);

    // ch0 to residue 3 with alternating bits, one-cycle reset, then a 1.
    drive(1'b1, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'h0);
    drive(1'b0, 4'b0001, 4'b0001, 4'h0);
    drive(1'b1, 4'b0001, 4'b0001, 4'h0);
    drive(1'b1, 4'b0001, 4'b0001, 4'h0);

    // Random traffic with sparse clears and resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] clr;
      logic       rn;
      clr = '0;
      for (int c = 0; c < 4; c++) clr[c] = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 59) != 0);
      drive(rn, 4'($urandom), 4'($urandom), clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
